// File: rtl/icape_reboot_ctrl.sv
// icape_reboot_ctrl
//   Wishbone master that drives the ICAPE2 configuration slave. A boot request
//   writes the warm-boot start address to WBSTAR, leaves one idle bus cycle,
//   then writes IPROG to CMD. A status request reads one configuration
//   register and holds the value on o_status. Every bus transaction is guarded
//   by an ack timeout.
//
// Ports
//   i_clk, i_reset      clock, asynchronous active-high reset
//   i_boot_req          pulse: start WBSTAR write + IPROG (address on i_boot_addr)
//   i_stat_req          pulse: read STAT_ADDR into o_status
//   o_busy              high from acceptance until back in IDLE
//   o_done / o_err      one-cycle completion / timeout pulses
//   o_status            last value returned by a status read
//   o_wb_*              Wishbone master request side (cyc/stb/we/addr/data)
//   i_wb_ack/stall/data Wishbone slave response side
module icape_reboot_ctrl #(
  parameter int          LGTIMEOUT   = 12,
  parameter logic [4:0]  WBSTAR_ADDR = 5'h10,
  parameter logic [4:0]  CMD_ADDR    = 5'h04,
  parameter logic [31:0] IPROG_CMD   = 32'h0000_000f,
  parameter logic [4:0]  STAT_ADDR   = 5'h16
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_boot_req,
  input  logic [31:0] i_boot_addr,
  input  logic        i_stat_req,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err,
  output logic [31:0] o_status,
  output logic        o_wb_cyc,
  output logic        o_wb_stb,
  output logic        o_wb_we,
  output logic [4:0]  o_wb_addr,
  output logic [31:0] o_wb_data,
  input  logic        i_wb_ack,
  input  logic        i_wb_stall,
  input  logic [31:0] i_wb_data
);

  typedef enum logic [2:0] {
    S_IDLE, S_WSTAR, S_GAP, S_WCMD, S_RSTAT, S_FINISH
  } state_t;

  state_t               state_q, state_d;
  logic [LGTIMEOUT-1:0] tmo_q, tmo_d;
  logic                 cyc_q, cyc_d;
  logic                 stb_q, stb_d;
  logic                 we_q, we_d;
  logic [4:0]           addr_q, addr_d;
  logic [31:0]          data_q, data_d;
  logic [31:0]          status_q, status_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;

  logic ack_ok;
  logic tmo_hit;

  // Acks only count inside a cycle; an ack on the terminal count still wins.
  assign ack_ok  = cyc_q && i_wb_ack;
  assign tmo_hit = cyc_q && !i_wb_ack && (tmo_q == '1);

  always_comb begin
    state_d  = state_q;
    tmo_d    = tmo_q;
    cyc_d    = cyc_q;
    stb_d    = stb_q;
    we_d     = we_q;
    addr_d   = addr_q;
    data_d   = data_q;
    status_d = status_q;
    done_d   = 1'b0;
    err_d    = 1'b0;

    // Exactly one request per transaction: drop stb once the slave takes it.
    if (stb_q && !i_wb_stall) stb_d = 1'b0;
    if (cyc_q) tmo_d = tmo_q + 1'b1;

    case (state_q)
      S_IDLE: begin
        if (i_boot_req) begin
          state_d = S_WSTAR;
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          we_d    = 1'b1;
          addr_d  = WBSTAR_ADDR;
          data_d  = i_boot_addr;
          tmo_d   = '0;
        end else if (i_stat_req) begin
          state_d = S_RSTAT;
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          we_d    = 1'b0;
          addr_d  = STAT_ADDR;
          data_d  = '0;
          tmo_d   = '0;
        end
      end
      S_WSTAR, S_WCMD, S_RSTAT: begin
        if (ack_ok) begin
          cyc_d = 1'b0;
          stb_d = 1'b0;
          if (state_q == S_RSTAT) status_d = i_wb_data;
          if (state_q == S_WSTAR) begin
            state_d = S_GAP;
          end else begin
            state_d = S_FINISH;
            done_d  = 1'b1;
          end
        end else if (tmo_hit) begin
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      // One cycle with cyc low so the slave retires the WBSTAR request.
      S_GAP: begin
        state_d = S_WCMD;
        cyc_d   = 1'b1;
        stb_d   = 1'b1;
        we_d    = 1'b1;
        addr_d  = CMD_ADDR;
        data_d  = IPROG_CMD;
        tmo_d   = '0;
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q  <= S_IDLE;
      tmo_q    <= '0;
      cyc_q    <= 1'b0;
      stb_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      status_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      tmo_q    <= tmo_d;
      cyc_q    <= cyc_d;
      stb_q    <= stb_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      status_q <= status_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign o_busy    = busy_q;
  assign o_done    = done_q;
  assign o_err     = err_q;
  assign o_status  = status_q;
  assign o_wb_cyc  = cyc_q;
  assign o_wb_stb  = stb_q;
  assign o_wb_we   = we_q;
  assign o_wb_addr = addr_q;
  assign o_wb_data = data_q;

endmodule

// File: tb/tb_icape_reboot_ctrl.sv
// Bench for icape_reboot_ctrl. Each request sequence is turned into a
// cycle-by-cycle plan (slave inputs plus the outputs the controller must show)
// from the sequence rules; a single loop drives and checks it.
module tb_icape_reboot_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        boot_req, stat_req;
  logic [31:0] boot_addr;
  logic        busy, done, err;
  logic [31:0] status;
  logic        wb_cyc, wb_stb, wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_wdata;
  logic        wb_ack, wb_stall;
  logic [31:0] wb_rdata;

  always #5 clk = ~clk;

  icape_reboot_ctrl dut (
    .i_clk(clk), .i_reset(rst),
    .i_boot_req(boot_req), .i_boot_addr(boot_addr), .i_stat_req(stat_req),
    .o_busy(busy), .o_done(done), .o_err(err), .o_status(status),
    .o_wb_cyc(wb_cyc), .o_wb_stb(wb_stb), .o_wb_we(wb_we),
    .o_wb_addr(wb_addr), .o_wb_data(wb_wdata),
    .i_wb_ack(wb_ack), .i_wb_stall(wb_stall), .i_wb_data(wb_rdata)
  );

  typedef struct {
    logic        boot;  logic stat;  logic [31:0] baddr;
    logic        stall; logic ack;   logic [31:0] rdata;
    logic        cyc;   logic stb;   logic we;
    logic [4:0]  addr;  logic [31:0] data;
    logic        busy;  logic done;  logic err;
    logic [31:0] status;
  } rec_t;

  rec_t        plan[$];
  logic [31:0] model_status;
  int          checks, errors, cyc_idx, n_xfers;

  // Bus episode monitor: length of each cyc-high run and requests inside it.
  int run_len = 0, reqs = 0, last_len = 0, ep_count = 0, bad_eps = 0;
  always @(negedge clk) begin
    if (wb_cyc) begin
      run_len++;
      if (wb_stb && !wb_stall) reqs++;
    end else if (run_len > 0) begin
      last_len = run_len;
      ep_count++;
      if (reqs != 1) bad_eps++;
      run_len = 0;
      reqs    = 0;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 30)
        $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc_idx, act, exp);
    end
  endtask

  function automatic rec_t idle_rec(input bit noise);
    rec_t r;
    r.boot = 1'b0; r.stat = 1'b0; r.baddr = $urandom;
    r.stall = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    r.ack   = noise && ($urandom_range(0, 3) == 0);
    r.rdata = $urandom;
    r.cyc = 1'b0; r.stb = 1'b0; r.we = 1'b0; r.addr = '0; r.data = '0;
    r.busy = 1'b0; r.done = 1'b0; r.err = 1'b0;
    r.status = model_status;
    return r;
  endfunction

  // One bus transaction: cyc is high from the cycle after entry until the
  // ack (dly cycles later), or for 4096 cycles when dly < 0 (no ack).
  // The slave stalls the first s cycles; stb must stay up through the
  // accepting cycle only.
  task automatic push_xfer(input logic we, input logic [4:0] a, input logic [31:0] d,
                           input int s, input int dly, input bit use_force,
                           input logic [31:0] force_rd, output bit ok, output logic [31:0] rd);
    int   n_hi;
    rec_t r;
    ok   = (dly >= 0) && (dly <= 4095);
    n_hi = ok ? dly + 1 : 4096;
    rd   = '0;
    n_xfers++;
    for (int k = 0; k < n_hi; k++) begin
      r = idle_rec(1'b0);
      r.boot  = ($urandom_range(0, 7) == 0);
      r.stat  = ($urandom_range(0, 7) == 0);
      r.stall = (k < s) ? 1'b1 : (k == s) ? 1'b0 : 1'($urandom_range(0, 1));
      r.ack   = ok && (k == dly);
      if (r.ack && use_force) r.rdata = force_rd;
      if (r.ack) rd = r.rdata;
      r.cyc = 1'b1; r.stb = (k <= s); r.we = we; r.addr = a; r.data = d;
      r.busy = 1'b1;
      plan.push_back(r);
    end
  endtask

  task automatic push_tail(input bit ok);
    rec_t r;
    if (ok) begin
      r = idle_rec(1'b1);
      r.busy = 1'b1; r.done = 1'b1;
      r.boot = ($urandom_range(0, 1) == 0); r.stat = ($urandom_range(0, 1) == 0);
      plan.push_back(r);
      plan.push_back(idle_rec(1'b1));
    end else begin
      r = idle_rec(1'b1);
      r.err = 1'b1;
      plan.push_back(r);
    end
  endtask

  task automatic plan_boot(input logic [31:0] addr, input bit both,
                           input int s1, input int d1, input int s2, input int d2);
    rec_t        r;
    bit          ok;
    logic [31:0] rd;
    r = idle_rec(1'b1);
    r.boot = 1'b1; r.stat = both; r.baddr = addr;
    plan.push_back(r);
    push_xfer(1'b1, 5'h10, addr, s1, d1, 1'b0, 32'h0, ok, rd);
    if (!ok) begin
      push_tail(1'b0);
      return;
    end
    r = idle_rec(1'b1);
    r.busy = 1'b1;
    r.boot = ($urandom_range(0, 1) == 0); r.stat = ($urandom_range(0, 1) == 0);
    plan.push_back(r);
    push_xfer(1'b1, 5'h04, 32'h0000_000f, s2, d2, 1'b0, 32'h0, ok, rd);
    push_tail(ok);
  endtask

  task automatic plan_stat(input int s, input int d, input bit use_force, input logic [31:0] force_rd);
    rec_t        r;
    bit          ok;
    logic [31:0] rd;
    r = idle_rec(1'b1);
    r.stat = 1'b1;
    plan.push_back(r);
    push_xfer(1'b0, 5'h16, 32'h0, s, d, use_force, force_rd, ok, rd);
    if (ok) model_status = rd;
    push_tail(ok);
  endtask

  task automatic push_idle(input int n);
    for (int i = 0; i < n; i++) plan.push_back(idle_rec(1'b1));
  endtask

  task automatic run_plan(input int max_n);
    rec_t r;
    int   n = 0;
    while (plan.size() > 0 && (max_n < 0 || n < max_n)) begin
      r = plan.pop_front();
      @(posedge clk);
      #1;
      cyc_idx++;
      chk("busy",   32'(busy),   32'(r.busy));
      chk("done",   32'(done),   32'(r.done));
      chk("err",    32'(err),    32'(r.err));
      chk("cyc",    32'(wb_cyc), 32'(r.cyc));
      chk("stb",    32'(wb_stb), 32'(r.stb));
      chk("status", status,      r.status);
      if (r.cyc) begin
        chk("we",   32'(wb_we),   32'(r.we));
        chk("addr", 32'(wb_addr), 32'(r.addr));
        chk("data", wb_wdata,     r.data);
      end
      boot_req = r.boot; stat_req = r.stat; boot_addr = r.baddr;
      wb_stall = r.stall; wb_ack = r.ack; wb_rdata = r.rdata;
      n++;
    end
  endtask

  task automatic idle_inputs();
    boot_req = 1'b0; stat_req = 1'b0; boot_addr = '0;
    wb_ack = 1'b0; wb_stall = 1'b0; wb_rdata = '0;
  endtask

  initial begin
    checks = 0; errors = 0; cyc_idx = 0; n_xfers = 0;
    model_status = '0;
    rst = 1'b1;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cyc",    32'(wb_cyc),  32'h0);
    chk("rst_stb",    32'(wb_stb),  32'h0);
    chk("rst_we",     32'(wb_we),   32'h0);
    chk("rst_addr",   32'(wb_addr), 32'h0);
    chk("rst_data",   wb_wdata,     32'h0);
    chk("rst_busy",   32'(busy),    32'h0);
    chk("rst_done",   32'(done),    32'h0);
    chk("rst_err",    32'(err),     32'h0);
    chk("rst_status", status,       32'h0);
    rst = 1'b0;

    // Read with ack 5 cycles in: request, 6 cyc cycles, done, idle.
    plan_stat(0, 5, 1'b1, 32'h1234_5678);
    chk("stat_plan_len", 32'(plan.size()), 32'd9);
    run_plan(-1);
    chk("stat_value", status, 32'h1234_5678);

    // Boot: request, 3 WSTAR cycles, gap, 3 WCMD cycles, done, idle.
    plan_boot(32'h0040_0000, 1'b0, 0, 2, 0, 2);
    chk("boot_plan_len", 32'(plan.size()), 32'd10);
    run_plan(-1);

    // Stall held 3 cycles on WSTAR; both requests in one cycle.
    plan_boot(32'ha5a5_0000, 1'b0, 3, 6, 0, 1);
    run_plan(-1);
    plan_boot($urandom, 1'b1, 0, 1, 1, 3);
    run_plan(-1);

    for (int i = 0; i < 30; i++) begin
      int s1, d1, s2, d2;
      s1 = int'($urandom_range(0, 3)); d1 = s1 + 1 + int'($urandom_range(0, 5));
      s2 = int'($urandom_range(0, 3)); d2 = s2 + 1 + int'($urandom_range(0, 5));
      if ($urandom_range(0, 1) == 1) plan_boot($urandom, 1'($urandom_range(0, 1)), s1, d1, s2, d2);
      else                           plan_stat(s1, d1, 1'b0, 32'h0);
      push_idle(int'($urandom_range(0, 3)));
      run_plan(-1);
    end

    // No ack on WSTAR: 4096 cycles of cyc, err, and no WCMD afterwards.
    plan_boot(32'hdead_0000, 1'b0, 1, -1, 0, 1);
    push_idle(6);
    run_plan(-1);
    chk("wstar_timeout_len", 32'(last_len), 32'd4096);

    // Ack on the terminal count is a success.
    plan_stat(0, 4095, 1'b1, 32'h0bad_cafe);
    run_plan(-1);
    chk("terminal_ack_len", 32'(last_len), 32'd4096);
    chk("terminal_ack_status", status, 32'h0bad_cafe);

    // Timed-out read leaves o_status alone; WCMD timeout reports err.
    plan_stat(2, -1, 1'b0, 32'h0);
    push_idle(2);
    run_plan(-1);
    chk("stat_timeout_keep", status, 32'h0bad_cafe);
    plan_boot($urandom, 1'b0, 0, 1, 0, -1);
    push_idle(2);
    run_plan(-1);

    // Reset while WCMD is on the bus.
    plan_boot(32'h1111_2222, 1'b0, 0, 2, 0, 20);
    run_plan(7);
    plan.delete();
    rst = 1'b1;
    idle_inputs();
    #1;
    chk("mid_rst_cyc",  32'(wb_cyc), 32'h0);
    chk("mid_rst_stb",  32'(wb_stb), 32'h0);
    chk("mid_rst_busy", 32'(busy),   32'h0);
    chk("mid_rst_done", 32'(done),   32'h0);
    chk("mid_rst_err",  32'(err),    32'h0);
    @(posedge clk);
    #1;
    chk("mid_rst_hold_cyc",  32'(wb_cyc), 32'h0);
    chk("mid_rst_hold_done", 32'(done),   32'h0);
    chk("mid_rst_hold_err",  32'(err),    32'h0);
    rst = 1'b0;
    model_status = '0;

    plan_stat(1, 4, 1'b1, 32'hcafe_f00d);
    run_plan(-1);
    chk("post_rst_stat", status, 32'hcafe_f00d);

    chk("one_request_per_xfer", 32'(bad_eps), 32'h0);
    chk("bus_episodes", 32'(ep_count), 32'(n_xfers));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
